// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the line-granular memory controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_t;

    // Number of byte-offset bits below the line index in a request address.
    function automatic int unsigned line_off_bits(input int unsigned line_width);
        return $clog2(line_width / 8);
    endfunction

endpackage

// File: rtl/mem_ctrl_req_fifo.sv
// Generic synchronous FIFO with asynchronous reset of pointers and occupancy.
module req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    // A push into a full queue is only legal when the head leaves on the same edge.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// In-order memory controller: queues tagged line requests, services them one at a
// time against a line-wide backing store with fixed latency, holds each response until acked.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned PA_WIDTH   = 32,
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned N_LINES    = 256,
    parameter int unsigned N_PENDING  = 4,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic [PA_WIDTH-1:0]   i_addr,
    input  logic [LINE_WIDTH-1:0] i_data,
    input  logic                  i_write,
    input  logic [ID_WIDTH-1:0]   i_id,
    output logic                  o_ack,
    output logic                  o_enable,
    output logic [ID_WIDTH-1:0]   o_id,
    output logic [LINE_WIDTH-1:0] o_data,
    input  logic                  i_ack
);

    localparam int unsigned OFF  = line_off_bits(LINE_WIDTH);
    localparam int unsigned IDXW = $clog2(N_LINES);
    localparam int unsigned CW   = $clog2(N_PENDING) + 1;
    localparam int unsigned CNTW = $clog2(LATENCY + 1);
    localparam logic [PA_WIDTH-1:0] IDX_MASK =
        ((PA_WIDTH'(1) << IDXW) - PA_WIDTH'(1)) << OFF;

    typedef struct packed {
        logic [IDXW-1:0]       idx;
        logic [LINE_WIDTH-1:0] data;
        logic                  write;
        logic [ID_WIDTH-1:0]   id;
    } req_t;

    localparam int unsigned REQ_W = $bits(req_t);

    mem_state_t            r_state;
    mem_state_t            w_state_nx;

    req_t                  w_req;
    req_t                  w_head;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_access;
    logic                  w_empty;
    logic                  w_full_unused;
    logic [CW-1:0]         w_count;
    logic                  w_addr_unused;

    logic [CNTW-1:0]       r_cnt;
    logic [IDXW-1:0]       r_idx;
    logic [LINE_WIDTH-1:0] r_data;
    logic                  r_write;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ID_WIDTH-1:0]   r_oid;
    logic [LINE_WIDTH-1:0] r_odata;
    logic [LINE_WIDTH-1:0] r_mem [N_LINES];

    assign w_addr_unused = ^(i_addr & ~IDX_MASK);
    assign w_req = '{idx: i_addr[OFF +: IDXW], data: i_data, write: i_write, id: i_id};

    // Acceptance looks only at the pre-edge occupancy; a same-cycle pop does not free a slot.
    assign o_ack  = i_enable && !rst && (w_count < CW'(N_PENDING));
    assign w_push = o_ack;
    assign o_id   = r_oid;
    assign o_data = r_odata;

    req_fifo #(
        .DEPTH (N_PENDING),
        .WIDTH (REQ_W)
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_req),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full_unused),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_state_nx = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nx = RESP;
                end
            end
            RESP: begin
                if (i_ack) begin
                    w_state_nx = w_empty ? IDLE : WAIT;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        w_pop    = 1'b0;
        w_access = 1'b0;
        o_enable = 1'b0;
        case (r_state)
            IDLE: w_pop = !w_empty;
            WAIT: w_access = (r_cnt == '0);
            RESP: begin
                o_enable = 1'b1;
                w_pop    = i_ack && !w_empty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_write <= 1'b0;
            r_id    <= '0;
            r_oid   <= '0;
            r_odata <= '0;
        end else begin
            if (w_pop) begin
                r_cnt   <= CNTW'(LATENCY - 1);
                r_idx   <= w_head.idx;
                r_data  <= w_head.data;
                r_write <= w_head.write;
                r_id    <= w_head.id;
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - CNTW'(1);
            end
            if (w_access) begin
                r_oid   <= r_id;
                r_odata <= r_write ? r_data : r_mem[r_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_access && r_write) begin
            r_mem[r_idx] <= r_data;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed requests push expected responses, a monitor checks them.
module tb_mem_ctrl;

    localparam int unsigned PA_W = 32;
    localparam int unsigned LW   = 128;
    localparam int unsigned IDW  = 4;
    localparam int unsigned NL   = 256;
    localparam int unsigned NP   = 4;
    localparam int unsigned LAT  = 4;

    logic            clk;
    logic            rst;
    logic            i_enable;
    logic [PA_W-1:0] i_addr;
    logic [LW-1:0]   i_data;
    logic            i_write;
    logic [IDW-1:0]  i_id;
    logic            o_ack;
    logic            o_enable;
    logic [IDW-1:0]  o_id;
    logic [LW-1:0]   o_data;
    logic            i_ack;

    mem_ctrl #(
        .PA_WIDTH   (PA_W),
        .LINE_WIDTH (LW),
        .ID_WIDTH   (IDW),
        .N_LINES    (NL),
        .N_PENDING  (NP),
        .LATENCY    (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_enable (i_enable),
        .i_addr   (i_addr),
        .i_data   (i_data),
        .i_write  (i_write),
        .i_id     (i_id),
        .o_ack    (o_ack),
        .o_enable (o_enable),
        .o_id     (o_id),
        .o_data   (o_data),
        .i_ack    (i_ack)
    );

    typedef struct {
        logic [IDW-1:0] id;
        logic [LW-1:0]  data;
    } exp_t;

    exp_t        sb[$];
    int unsigned resp_cyc[$];
    exp_t        mon_e;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    logic        seen    = 1'b0;
    logic        consume_next = 1'b0;

    localparam logic [LW-1:0] PAT_A5 = {16{8'hA5}};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: each new response is compared once against the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
            consume_next = 1'b0;
        end else begin
            if (consume_next) seen = 1'b0;
            consume_next = 1'b0;
            if (o_enable && !seen) begin
                seen = 1'b1;
                resp_cyc.push_back(cyc);
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_resp: got id %0d data %h, expected no response", o_id, o_data);
                end else begin
                    mon_e = sb.pop_front();
                    if (o_id !== mon_e.id || o_data !== mon_e.data) begin
                        n_fail++;
                        $display("FAIL resp: got id %0d data %h, expected id %0d data %h",
                                 o_id, o_data, mon_e.id, mon_e.data);
                    end
                end
            end
            if (o_enable && i_ack) consume_next = 1'b1;
        end
    end

    // All stimulus tasks start and end at the drive point, 1 time unit after a rising edge.
    task automatic issue(input logic wr, input logic [PA_W-1:0] a, input logic [LW-1:0] d,
                         input logic [IDW-1:0] id, input logic [LW-1:0] exp_d,
                         output int unsigned acc);
        bit done;
        done = 1'b0;
        acc = 0;
        i_enable = 1'b1;
        i_write  = wr;
        i_addr   = a;
        i_data   = d;
        i_id     = id;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (o_ack) begin
                sb.push_back('{id: id, data: exp_d});
                acc  = cyc + 1;
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        i_enable = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: id %0d never acked, expected o_ack within 100 cycles", id);
        end
    endtask

    task automatic wait_resp(output int unsigned c);
        bit found;
        found = 1'b0;
        c = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (o_enable) begin
                c = cyc;
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp_timeout: got no o_enable, expected a response within 100 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic ack_resp();
        i_ack = 1'b1;
        @(posedge clk); #1;
        i_ack = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d outstanding, expected 0", sb.size());
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        int unsigned acc;
        int unsigned rc;
        int unsigned n_seen;

        rst = 1'b1;
        i_enable = 1'b1;
        i_addr = '0;
        i_data = '0;
        i_write = 1'b0;
        i_id = '0;
        i_ack = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_o_ack", LW'(o_ack), '0);
        check("rst_o_enable", LW'(o_enable), '0);
        check("rst_o_id", LW'(o_id), '0);
        check("rst_o_data", o_data, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        i_enable = 1'b0;

        // Stray ack while idle must be ignored.
        ack_resp();
        @(negedge clk);
        check("idle_ack_ignored", LW'(o_enable), '0);
        @(posedge clk); #1;

        // Single write then read, with exact latency.
        issue(1'b1, 32'h40, PAT_A5, 4'd1, PAT_A5, acc);
        wait_resp(rc);
        check("lat_write", LW'(rc - acc), LW'(LAT + 1));
        ack_resp();
        @(negedge clk);
        check("drop_after_ack_w", LW'(o_enable), '0);
        @(posedge clk); #1;

        issue(1'b0, 32'h40, '0, 4'd2, PAT_A5, acc);
        wait_resp(rc);
        check("lat_read", LW'(rc - acc), LW'(LAT + 1));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_en", LW'(o_enable), LW'(1));
            check("stall_id", LW'(o_id), LW'(2));
            check("stall_data", o_data, PAT_A5);
        end
        @(posedge clk); #1;
        ack_resp();
        @(negedge clk);
        check("drop_after_ack_r", LW'(o_enable), '0);
        @(posedge clk); #1;

        // Fill: one in service plus N_PENDING queued, the sixth is refused.
        for (int k = 0; k < 6; k++) begin
            i_enable = 1'b1;
            i_write  = 1'b0;
            i_addr   = 32'h40;
            i_id     = IDW'(k);
            @(negedge clk);
            check("fill_ack", LW'(o_ack), LW'(k < 5));
            if (o_ack) sb.push_back('{id: IDW'(k), data: PAT_A5});
            @(posedge clk); #1;
        end
        wait_resp(rc);
        i_ack = 1'b1;
        @(negedge clk);
        check("no_pop_bypass", LW'(o_ack), '0);
        @(posedge clk); #1;
        i_ack = 1'b0;
        @(negedge clk);
        check("id5_acked", LW'(o_ack), LW'(1));
        if (o_ack) sb.push_back('{id: IDW'(5), data: PAT_A5});
        @(posedge clk); #1;
        i_enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_resp(rc);
            ack_resp();
        end

        // Back-to-back with i_ack tied high.
        i_ack = 1'b1;
        resp_cyc.delete();
        for (int k = 6; k < 9; k++) issue(1'b0, 32'h40, '0, IDW'(k), PAT_A5, acc);
        wait_drain();
        check("b2b_count", LW'(resp_cyc.size()), LW'(3));
        if (resp_cyc.size() >= 3) begin
            check("b2b_gap0", LW'(resp_cyc[1] - resp_cyc[0]), LW'(LAT + 1));
            check("b2b_gap1", LW'(resp_cyc[2] - resp_cyc[1]), LW'(LAT + 1));
        end

        // Aliasing through ignored upper and offset address bits.
        issue(1'b1, 32'h40, {4{32'h1111_2222}}, 4'd9, {4{32'h1111_2222}}, acc);
        issue(1'b1, 32'h40 + NL * LW / 8, {4{32'h3333_4444}}, 4'd10, {4{32'h3333_4444}}, acc);
        issue(1'b0, 32'h40, '0, 4'd11, {4{32'h3333_4444}}, acc);
        issue(1'b0, 32'h4F, '0, 4'd12, {4{32'h3333_4444}}, acc);
        wait_drain();

        // Pointer wrap: 12 in-order requests.
        for (int k = 0; k < 6; k++)
            issue(1'b1, 32'h100 + 32'(k) * 16, {4{32'hC0DE_0000 + 32'(k)}}, IDW'(k),
                  {4{32'hC0DE_0000 + 32'(k)}}, acc);
        for (int k = 0; k < 6; k++)
            issue(1'b0, 32'h100 + 32'(k) * 16, '0, IDW'(k + 6),
                  {4{32'hC0DE_0000 + 32'(k)}}, acc);
        wait_drain();
        check("sb_drained", LW'(sb.size()), '0);
        i_ack = 1'b0;

        // Reset mid-WAIT with two requests queued.
        for (int k = 1; k < 4; k++) issue(1'b0, 32'h40, '0, IDW'(k), PAT_A5, acc);
        i_enable = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_o_enable", LW'(o_enable), '0);
        check("mid_rst_o_ack", LW'(o_ack), '0);
        check("mid_rst_o_id", LW'(o_id), '0);
        check("mid_rst_o_data", o_data, '0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        i_enable = 1'b0;
        n_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_enable) n_seen++;
        end
        check("no_resp_after_rst", LW'(n_seen), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion within 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
